// File: rtl/complex_result_arbiter_pkg.sv
// cmul_defs: shared widths for the complex multiplier result path.
package cmul_defs;
    localparam int NUM_CH         = 4;
    localparam int TAG_W          = 4;
    localparam int DATA_WIDTH_DEF = 8;

    function automatic int res_part_w(input int dw);
        return 2 * dw;
    endfunction

    function automatic int res_w(input int dw);
        return 4 * dw + TAG_W;
    endfunction
endpackage

// File: rtl/complex_result_arbiter_rr.sv
// rr_arbiter_4: four-way round-robin grant starting the search at ptr_i.
module rr_arbiter_4 import cmul_defs::*; (
    input  logic [NUM_CH-1:0] req_i,
    input  logic              en_i,
    input  logic [1:0]        ptr_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [1:0]        ptr_nxt_o
);
    logic [1:0] idx;

    // Walk the search order backwards so the closest requester to ptr_i wins.
    always_comb begin
        grant_o   = '0;
        ptr_nxt_o = ptr_i;
        idx       = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = ptr_i + 2'(k);
            if (en_i && req_i[idx]) begin
                grant_o   = NUM_CH'(1) << idx;
                ptr_nxt_o = idx + 2'd1;
            end
        end
    end
endmodule

// File: rtl/complex_result_arbiter.sv
// complex_result_arbiter: round-robin merge of four complex-multiplier result
// streams into one tagged, registered output stream.
module complex_result_arbiter import cmul_defs::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           sw_rst_i,
    input  logic [NUM_CH-1:0]              ch_val_i,
    output logic [NUM_CH-1:0]              ch_ready_o,
    input  logic [NUM_CH*4*DATA_WIDTH-1:0] ch_data_i,
    output logic                           res_val_o,
    input  logic                           res_ready_i,
    output logic [4*DATA_WIDTH+TAG_W-1:0]  res_data_o
);
    localparam int RES_PART_W = res_part_w(DATA_WIDTH);
    localparam int RES_W      = res_w(DATA_WIDTH);
    localparam int SLICE_W    = 2 * RES_PART_W;

    logic              res_val_q, res_val_d;
    logic [RES_W-1:0]  res_data_q, res_data_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d, ptr_nxt;
    logic [NUM_CH-1:0] grant;
    logic              load_en;

    assign load_en = ~res_val_q | res_ready_i;

    rr_arbiter_4 u_arb (
        .req_i     (ch_val_i),
        .en_i      (load_en & ~sw_rst_i),
        .ptr_i     (rr_ptr_q),
        .grant_o   (grant),
        .ptr_nxt_o (ptr_nxt)
    );

    // rstn gates only the port so handshakes stop the instant reset asserts.
    assign ch_ready_o = grant & {NUM_CH{rstn}};
    assign res_val_o  = res_val_q;
    assign res_data_o = res_data_q;

    always_comb begin
        res_val_d  = res_val_q & ~res_ready_i;
        res_data_d = res_data_q;
        rr_ptr_d   = rr_ptr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                res_val_d  = 1'b1;
                res_data_d = {grant, ch_data_i[i*SLICE_W +: SLICE_W]};
                rr_ptr_d   = ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_val_q  <= 1'b0;
            res_data_q <= '0;
            rr_ptr_q   <= '0;
        end else if (sw_rst_i) begin
            res_val_q  <= 1'b0;
            res_data_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            res_val_q  <= res_val_d;
            res_data_q <= res_data_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end
endmodule

// File: tb/tb_complex_result_arbiter.sv
// tb_complex_result_arbiter: directed and randomized checks of the result merger
// against a behavioural model of the arbitration rules.
module tb_complex_result_arbiter;
    localparam int DW = 8;
    localparam int SW = 4 * DW;
    localparam int RW = 4 * DW + 4;

    logic          clk = 1'b0;
    logic          rstn, sw_rst, res_ready, res_val;
    logic [3:0]    ch_val, ch_ready;
    logic [4*SW-1:0] ch_data;
    logic [RW-1:0] res_data;

    int n_chk = 0;
    int n_fail = 0;

    logic          m_val;
    logic [RW-1:0] m_data;
    int            m_ptr;
    logic [3:0]    last_g;
    int            wait_cnt [4];
    logic [3:0]    t2_tags [5];
    logic [3:0]    t4_tags [4];

    always #5 clk = ~clk;

    complex_result_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .sw_rst_i    (sw_rst),
        .ch_val_i    (ch_val),
        .ch_ready_o  (ch_ready),
        .ch_data_i   (ch_data),
        .res_val_o   (res_val),
        .res_ready_i (res_ready),
        .res_data_o  (res_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_val  = 1'b0;
        m_data = '0;
        m_ptr  = 0;
        for (int c = 0; c < 4; c++) wait_cnt[c] = 0;
    endtask

    // Grant = first valid channel in the order ptr, ptr+1, ... when the output can load.
    function automatic logic [3:0] exp_grant();
        int c;
        if (!rstn || sw_rst || (m_val && !res_ready)) return 4'b0000;
        for (int k = 0; k < 4; k++) begin
            c = (m_ptr + k) % 4;
            if (ch_val[c]) return 4'(1 << c);
        end
        return 4'b0000;
    endfunction

    task automatic cyc();
        int gi;
        @(negedge clk);
        last_g = exp_grant();
        chk("ch_ready", ch_ready, last_g);
        chk("res_val", res_val, m_val);
        chk("res_data", res_data, m_data);
        for (int c = 0; c < 4; c++) begin
            if (!ch_val[c] || !rstn) wait_cnt[c] = 0;
            else if (ch_ready[c]) wait_cnt[c] = 0;
            else if (ch_ready != 4'b0000) begin
                wait_cnt[c]++;
                chk("fairness", wait_cnt[c] <= 3, 1);
            end
        end
        @(posedge clk);
        if (!rstn || sw_rst) model_reset();
        else if (last_g != 4'b0000) begin
            gi = 0;
            for (int c = 0; c < 4; c++) if (last_g[c]) gi = c;
            m_val  = 1'b1;
            m_data = {last_g, ch_data[gi*SW +: SW]};
            m_ptr  = (gi + 1) % 4;
        end else if (res_ready) m_val = 1'b0;
        #1;
    endtask

    initial begin
        t2_tags = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        t4_tags = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};
        rstn = 1'b0; sw_rst = 1'b0; ch_val = 4'hF; ch_data = '0; res_ready = 1'b1;
        model_reset();
        #1;
        chk("rst_val", res_val, 0);
        chk("rst_ready", ch_ready, 0);
        chk("rst_data", res_data, 0);
        repeat (2) cyc();

        rstn = 1'b1;
        ch_val = 4'b0100;
        ch_data[2*SW +: SW] = {16'h0010, 16'h0020};
        #1;
        chk("t1_ready", ch_ready, 4'b0100);
        cyc();
        chk("t1_val", res_val, 1);
        chk("t1_data", res_data, 36'h4_0010_0020);
        ch_val = 4'b0000;

        for (int i = 0; i < 4; i++) ch_data[i*SW +: SW] = {16'(16'h1000 + i), 16'(16'h2000 + i)};
        sw_rst = 1'b1;
        ch_val = 4'hF;
        #1;
        chk("t2_swrst_ready", ch_ready, 0);
        cyc();
        sw_rst = 1'b0;
        chk("t2_swrst_val", res_val, 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t2_tag", res_data[RW-1 -: 4], t2_tags[i]);
        end

        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_ready", ch_ready, 0);
            cyc();
            chk("t3_hold", res_data, 36'h1_1000_2000);
        end
        res_ready = 1'b1;
        #1;
        chk("t3_reload_ready", ch_ready, 4'b0010);
        cyc();
        chk("t3_reload_val", res_val, 1);
        chk("t3_reload_data", res_data, 36'h2_1001_2001);

        ch_val = 4'b0001;
        repeat (2) cyc();
        ch_val = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t4_tag", res_data[RW-1 -: 4], t4_tags[i]);
        end

        sw_rst = 1'b1;
        #1;
        chk("t5_swrst_ready", ch_ready, 0);
        cyc();
        sw_rst = 1'b0;
        chk("t5_val", res_val, 0);
        chk("t5_data", res_data, 0);
        #1;
        chk("t5_restart", ch_ready, 4'b0001);
        cyc();
        chk("t5_tag", res_data[RW-1 -: 4], 4'b0001);

        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 253) rstn = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (last_g[c]) begin
                    ch_val[c] = ($urandom_range(0, 3) != 0);
                    ch_data[c*SW +: SW] = $urandom;
                end else if (!ch_val[c] && $urandom_range(0, 2) == 0) begin
                    ch_val[c] = 1'b1;
                    ch_data[c*SW +: SW] = $urandom;
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            sw_rst = ($urandom_range(0, 60) == 0);
            if (n % 500 == 250) begin
                #2;
                rstn = 1'b0;
                model_reset();
                #1;
                chk("arst_val", res_val, 0);
                chk("arst_ready", ch_ready, 0);
                chk("arst_data", res_data, 0);
                ch_val = 4'b0000;
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
